// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for the loadable up/down modulo counter.
// The master drives the controls and the load value; the counter (slave) returns the count and its flags.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             up_down;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf_sticky;

  modport master (
    output enable, load, data, up_down, ovf_clr,
    input  count, tc, wrap, ovf_sticky
  );

  modport slave (
    input  enable, load, data, up_down, ovf_clr,
    output count, tc, wrap, ovf_sticky
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Parametrised loadable up/down modulo counter with wrap or saturate behaviour at the range ends,
// a combinational terminal-count look-ahead, a registered wrap pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_mod_counter_if.slave  bus
);

  // Top of the count range; the WIDTH+1 form lets the load clamp compare without overflow.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf_sticky;

  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_at_end;
  logic             w_event;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
    if ({1'b0, val} > TOP_EXT) begin
      return TOP;
    end
    return val;
  endfunction

  assign w_at_top   = (r_count == TOP);
  assign w_at_zero  = (r_count == '0);
  assign w_at_end   = bus.up_down ? w_at_top : w_at_zero;
  assign w_event    = bus.enable & ~bus.load & w_at_end;
  assign w_load_val = clamp_load(bus.data);

  // Next-count selection: load beats enable, enable beats hold.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.load) begin
      w_count_nxt = w_load_val;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        if (!w_at_top) begin
          w_count_nxt = r_count + WIDTH'(1);
        end else if (!SATURATE) begin
          w_count_nxt = '0;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_nxt = r_count - WIDTH'(1);
        end else if (!SATURATE) begin
          w_count_nxt = TOP;
        end
      end
    end
  end

  // Register stage: count, wrap pulse and sticky flag all update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= '0;
      r_wrap       <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_event;
      if (w_event) begin
        r_ovf_sticky <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

  assign bus.count      = r_count;
  assign bus.wrap       = r_wrap;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.tc         = w_event;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed and randomized bench for updown_mod_counter: one wrapping and one saturating instance
// (WIDTH=4, MODULUS=10) share the same stimulus and are compared against a arithmetic reference model.
module tb_updown_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, ld, ud, clr;
  logic [W-1:0] dt;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(W)) bw ();
  updown_mod_counter_if #(.WIDTH(W)) bs ();

  assign bw.enable  = en;
  assign bw.load    = ld;
  assign bw.data    = dt;
  assign bw.up_down = ud;
  assign bw.ovf_clr = clr;
  assign bs.enable  = en;
  assign bs.load    = ld;
  assign bs.data    = dt;
  assign bs.up_down = ud;
  assign bs.ovf_clr = clr;

  updown_mod_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bw)
  );

  updown_mod_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1'b1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bs)
  );

  int checks = 0;
  int errors = 0;
  // Model state, index 0 = wrapping instance, 1 = saturating instance.
  int m_cnt  [2];
  int m_wrap [2];
  int m_ovf  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 0;
      m_ovf[i]  = 0;
    end
  endtask

  function automatic int model_tc(input int i);
    int end_val;
    end_val = ud ? M - 1 : 0;
    return (en && !ld && m_cnt[i] == end_val) ? 1 : 0;
  endfunction

  // Step one edge: an unbounded +/-1 that leaves 0..M-1 is a range-end event.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int  nxt;
      bit  ev;
      ev = 1'b0;
      if (ld) begin
        m_cnt[i]  = (int'(dt) > M - 1) ? M - 1 : int'(dt);
        m_wrap[i] = 0;
      end else if (en) begin
        nxt = m_cnt[i] + (ud ? 1 : -1);
        ev  = (nxt < 0) || (nxt > M - 1);
        if (!ev)        m_cnt[i] = nxt;
        else if (i == 0) m_cnt[i] = (nxt + M) % M;
        m_wrap[i] = ev ? 1 : 0;
      end else begin
        m_wrap[i] = 0;
      end
      if (ev)       m_ovf[i] = 1;
      else if (clr) m_ovf[i] = 0;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":wrap.count"}, 32'(bw.count),      32'(m_cnt[0]));
    chk({tag, ":wrap.wrap"},  32'(bw.wrap),       32'(m_wrap[0]));
    chk({tag, ":wrap.ovf"},   32'(bw.ovf_sticky), 32'(m_ovf[0]));
    chk({tag, ":sat.count"},  32'(bs.count),      32'(m_cnt[1]));
    chk({tag, ":sat.wrap"},   32'(bs.wrap),       32'(m_wrap[1]));
    chk({tag, ":sat.ovf"},    32'(bs.ovf_sticky), 32'(m_ovf[1]));
  endtask

  task automatic tick(input string tag);
    #1;
    chk({tag, ":wrap.tc"}, 32'(bw.tc), 32'(model_tc(0)));
    chk({tag, ":sat.tc"},  32'(bs.tc), 32'(model_tc(1)));
    @(posedge clk);
    model_step();
    #1;
    check_regs(tag);
  endtask

  task automatic drive(input logic e, input logic l, input logic u, input logic c, input int d);
    en  = e;
    ld  = l;
    ud  = u;
    clr = c;
    dt  = W'(d);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 1, 0, 0);
    model_reset();
    #2;
    check_regs("reset_init");
    reset = 1'b1;

    drive(0, 1, 1, 0, 3);   tick("load3");
    drive(0, 1, 1, 0, 14);  tick("load14_clamp");
    drive(0, 1, 1, 0, 15);  tick("load15_clamp");

    // Up across the top: 8 -> 9 -> end event -> 1
    drive(0, 1, 1, 0, 8);   tick("up_load8");
    drive(1, 0, 1, 0, 0);
    tick("up_to9");
    tick("up_wrap");
    tick("up_after");

    drive(0, 0, 1, 1, 0);   tick("ovf_clear");

    // Down into the bottom three times
    drive(0, 1, 0, 0, 1);   tick("dn_load1");
    drive(1, 0, 0, 0, 0);
    tick("dn_0");
    tick("dn_hold1");
    tick("dn_hold2");

    // Load beats enable at the top end
    drive(0, 1, 1, 0, 9);   tick("pri_load9");
    drive(1, 1, 1, 0, 5);   tick("pri_load5");
    drive(0, 1, 1, 0, 9);   tick("pri_reload9");
    drive(1, 0, 1, 1, 0);   tick("pri_set_vs_clr");
    drive(0, 0, 1, 1, 0);   tick("pri_clr_after");

    // Hold then direction toggling
    drive(0, 1, 1, 0, 6);   tick("hold_load6");
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, k[0], 0, 0);
      tick("hold");
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, ~k[0], 0, 0);
      tick("toggle");
    end

    // Asynchronous reset in the middle of a count with the sticky flag set
    drive(0, 1, 1, 0, 9);   tick("rst_load9");
    drive(1, 0, 1, 0, 0);   tick("rst_setovf");
    drive(0, 1, 1, 0, 7);   tick("rst_load7");
    drive(1, 0, 1, 0, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_regs("rst_async");
    #2;
    reset = 1'b1;
    tick("rst_release");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 15)));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
